// File: rtl/ej32_pkg.sv
// Shared types for the ej32 core; the instruction fetch unit uses fetch_st_t.
package ej32_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    sFILL  = 1'b0,
    sFLUSH = 1'b1
  } fetch_st_t;

endpackage

// File: rtl/ej32_ifetch_fifo.sv
// Circular prefetch buffer holding (byte, address) pairs with an occupancy count.
// Writes land only when not full; pops take effect only while vld_o=1; clr wins over both.
module ifetch_fifo
  import ej32_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ASZ   = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [BYTE_W-1:0]        wr_byte,
  input  logic [ASZ-1:0]           wr_pc,
  input  logic                     rd_en,
  output logic                     vld_o,
  output logic [BYTE_W-1:0]        byte_o,
  output logic [ASZ-1:0]           pc_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] r_byte [DEPTH];
  logic [ASZ-1:0]    r_pc   [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_cnt;

  logic w_vld;
  logic w_wr;
  logic w_rd;

  assign w_vld = (r_cnt != '0);
  assign w_wr  = wr_en && (r_cnt != DEPTH_V) && !clr && !rst;
  assign w_rd  = rd_en && w_vld && !clr && !rst;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_byte[r_wp] <= wr_byte;
      r_pc[r_wp]   <= wr_pc;
    end
  end

  assign vld_o  = w_vld;
  assign byte_o = w_vld ? r_byte[r_rp] : '0;
  assign pc_o   = w_vld ? r_pc[r_rp]   : '0;
  assign cnt_o  = r_cnt;

endmodule

// File: rtl/ej32_ifetch.sv
// Byte-serial instruction prefetch: issues one read per cycle while the buffer has room,
// discards in-flight data on redirect and refills from the new target.
module ej32_ifetch
  import ej32_pkg::*;
#(
  parameter int unsigned    ASZ    = 17,
  parameter int unsigned    DEPTH  = 4,
  parameter logic [ASZ-1:0] RST_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_rd_o,
  output logic [ASZ-1:0]         mem_addr_o,
  input  logic [BYTE_W-1:0]      mem_data_i,
  input  logic                   jmp_i,
  input  logic [ASZ-1:0]         jmp_pc_i,
  input  logic                   take_i,
  output logic                   vld_o,
  output logic [BYTE_W-1:0]      byte_o,
  output logic [ASZ-1:0]         pc_o,
  output logic [$clog2(DEPTH):0] cnt_o,
  output fetch_st_t              dbg_st_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_st_t      r_st;
  fetch_st_t      w_st_nxt;
  logic [ASZ-1:0] r_fpc;
  logic           r_infl;
  logic [ASZ-1:0] r_infl_pc;
  logic           w_issue;
  logic           w_room;
  logic [AW:0]    w_cnt;
  logic [AW+1:0]  w_occ;

  // Memory latency is one cycle, so at most one read is ever outstanding.
  assign w_occ  = {1'b0, w_cnt} + {{(AW+1){1'b0}}, r_infl};
  assign w_room = (w_occ < (AW+2)'(DEPTH));

  always_comb begin
    w_st_nxt = r_st;
    w_issue  = 1'b0;
    if (jmp_i) begin
      w_st_nxt = sFLUSH;
    end else begin
      case (r_st)
        sFILL:   w_issue = w_room;
        sFLUSH: begin
          w_issue  = 1'b1;
          w_st_nxt = sFILL;
        end
        default: w_st_nxt = sFILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= sFILL;
      r_fpc     <= RST_PC;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
    end else begin
      r_st      <= w_st_nxt;
      r_infl    <= w_issue;
      r_infl_pc <= r_fpc;
      if (jmp_i)        r_fpc <= jmp_pc_i;
      else if (w_issue) r_fpc <= r_fpc + ASZ'(1);
    end
  end

  assign mem_rd_o   = w_issue && !rst;
  assign mem_addr_o = r_fpc;
  assign dbg_st_o   = r_st;

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .ASZ   (ASZ)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (jmp_i),
    .wr_en   (r_infl),
    .wr_byte (mem_data_i),
    .wr_pc   (r_infl_pc),
    .rd_en   (take_i),
    .vld_o   (vld_o),
    .byte_o  (byte_o),
    .pc_o    (pc_o),
    .cnt_o   (w_cnt)
  );

  assign cnt_o = w_cnt;

endmodule

// File: tb/tb_ej32_ifetch.sv
// Directed bench for ej32_ifetch against a one-cycle-latency byte memory (data = addr[7:0]+0x10).
module tb_ej32_ifetch;
  import ej32_pkg::*;

  localparam int ASZ   = 17;
  localparam int DEPTH = 4;

  logic           clk        = 1'b0;
  logic           rst        = 1'b1;
  logic           mem_rd_o;
  logic [ASZ-1:0] mem_addr_o;
  logic [7:0]     mem_data_i = 8'h00;
  logic           jmp_i      = 1'b0;
  logic [ASZ-1:0] jmp_pc_i   = '0;
  logic           take_i     = 1'b0;
  logic           vld_o;
  logic [7:0]     byte_o;
  logic [ASZ-1:0] pc_o;
  logic [2:0]     cnt_o;
  fetch_st_t      dbg_st_o;

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;
  int base     = 0;

  // clock / reset
  always #5 clk = ~clk;

  ej32_ifetch #(
    .ASZ    (ASZ),
    .DEPTH  (DEPTH),
    .RST_PC (17'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rd_o   (mem_rd_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .jmp_i      (jmp_i),
    .jmp_pc_i   (jmp_pc_i),
    .take_i     (take_i),
    .vld_o      (vld_o),
    .byte_o     (byte_o),
    .pc_o       (pc_o),
    .cnt_o      (cnt_o),
    .dbg_st_o   (dbg_st_o)
  );

  function automatic logic [7:0] mem_f(input logic [ASZ-1:0] a);
    return a[7:0] + 8'h10;
  endfunction

  // memory model: data valid one cycle after the request, junk otherwise
  always @(posedge clk) begin
    mem_data_i <= mem_rd_o ? mem_f(mem_addr_o) : 8'hEE;
    if (mem_rd_o) rd_cnt <= rd_cnt + 1;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    rst = 1'b1; take_i = 1'b1; tick(); tick();
    smp();
    chk("rst_rd",   32'(mem_rd_o), 0);
    chk("rst_vld",  32'(vld_o),    0);
    chk("rst_cnt",  32'(cnt_o),    0);
    chk("rst_byte", 32'(byte_o),   0);
    chk("rst_pc",   32'(pc_o),     0);
    chk("rst_st",   32'(dbg_st_o), 32'(sFILL));
    tick();

    // streaming with take_i held high
    rst = 1'b0;
    smp(); chk("t1_rd0", 32'(mem_rd_o), 1); chk("t1_addr0", 32'(mem_addr_o), 0); tick();
    smp(); chk("t1_vld_c1", 32'(vld_o), 0); tick();
    smp(); chk("t1_vld_c2", 32'(vld_o), 1); chk("t1_b0", 32'(byte_o), 32'h10); chk("t1_pc0", 32'(pc_o), 0); tick();
    smp(); chk("t1_b1", 32'(byte_o), 32'h11); chk("t1_pc1", 32'(pc_o), 1); tick();
    smp(); chk("t1_b2", 32'(byte_o), 32'h12); chk("t1_pc2", 32'(pc_o), 2); chk("t1_vld", 32'(vld_o), 1);

    // no consumer: fill to DEPTH then stall
    tick(); rst = 1'b1; tick();
    rst = 1'b0; take_i = 1'b0; base = rd_cnt;
    repeat (8) tick();
    smp();
    chk("t2_reads", 32'(rd_cnt - base), 4);
    chk("t2_cnt",   32'(cnt_o),    4);
    chk("t2_rd",    32'(mem_rd_o), 0);
    chk("t2_b0",    32'(byte_o),   32'h10);
    tick(); take_i = 1'b1;
    smp(); chk("t2_vld", 32'(vld_o), 1); tick(); take_i = 1'b0;
    smp(); chk("t2_refill_rd", 32'(mem_rd_o), 1); chk("t2_refill_addr", 32'(mem_addr_o), 4); tick();
    smp(); chk("t2_stall_rd", 32'(mem_rd_o), 0); tick();
    smp();
    chk("t2_reads5", 32'(rd_cnt - base), 5);
    chk("t2_cnt4",   32'(cnt_o),  4);
    chk("t2_b1",     32'(byte_o), 32'h11);
    chk("t2_pc1",    32'(pc_o),   1);

    // redirect with 3 buffered and 1 in flight
    tick(); rst = 1'b1; tick();
    rst = 1'b0; take_i = 1'b0;
    repeat (4) tick();
    jmp_i = 1'b1; jmp_pc_i = 17'h100;
    smp(); chk("t3_pre_cnt", 32'(cnt_o), 3); chk("t3_jmp_rd", 32'(mem_rd_o), 0); tick();
    jmp_i = 1'b0;
    smp();
    chk("t3_cnt0",  32'(cnt_o),      0);
    chk("t3_vld0",  32'(vld_o),      0);
    chk("t3_st",    32'(dbg_st_o),   32'(sFLUSH));
    chk("t3_rd",    32'(mem_rd_o),   1);
    chk("t3_addr",  32'(mem_addr_o), 32'h100);
    tick();
    smp(); chk("t3_vld_j2", 32'(vld_o), 0); tick();
    smp();
    chk("t3_vld_j3", 32'(vld_o),  1);
    chk("t3_byte",   32'(byte_o), 32'h10);
    chk("t3_pc",     32'(pc_o),   32'h100);
    chk("t3_cnt1",   32'(cnt_o),  1);

    // jmp+take together, then back-to-back jmps
    tick(); take_i = 1'b1; jmp_i = 1'b1; jmp_pc_i = 17'h20;
    smp(); chk("t4_rd_j1", 32'(mem_rd_o), 0); chk("t4_cnt_pre", 32'(cnt_o), 2); tick();
    take_i = 1'b0; jmp_pc_i = 17'h40;
    smp();
    chk("t4_cnt0",  32'(cnt_o),    0);
    chk("t4_vld0",  32'(vld_o),    0);
    chk("t4_rd_j2", 32'(mem_rd_o), 0);
    chk("t4_st",    32'(dbg_st_o), 32'(sFLUSH));
    tick(); jmp_i = 1'b0;
    smp(); chk("t4_rd", 32'(mem_rd_o), 1); chk("t4_addr", 32'(mem_addr_o), 32'h40); tick();
    smp(); chk("t4_vld_w", 32'(vld_o), 0); tick(); take_i = 1'b1;
    smp(); chk("t4_vld", 32'(vld_o), 1); chk("t4_b40", 32'(byte_o), 32'h50); chk("t4_pc40", 32'(pc_o), 32'h40); tick();
    take_i = 1'b0;
    smp(); chk("t4_b41", 32'(byte_o), 32'h51); chk("t4_pc41", 32'(pc_o), 32'h41); chk("t4_cnt", 32'(cnt_o), 1);

    // address wrap and take_i ignored while empty
    tick(); jmp_i = 1'b1; jmp_pc_i = 17'h1FFFF;
    smp(); tick();
    jmp_i = 1'b0; take_i = 1'b1;
    smp(); chk("t5_addr_top", 32'(mem_addr_o), 32'h1FFFF); chk("t5_vld_e", 32'(vld_o), 0); tick();
    smp(); chk("t5_addr_wrap", 32'(mem_addr_o), 0); chk("t5_rd", 32'(mem_rd_o), 1); chk("t5_cnt_e", 32'(cnt_o), 0); tick();
    smp(); chk("t5_b_top", 32'(byte_o), 32'h0F); chk("t5_pc_top", 32'(pc_o), 32'h1FFFF); chk("t5_cnt1", 32'(cnt_o), 1); tick();
    take_i = 1'b0;
    smp(); chk("t5_b0", 32'(byte_o), 32'h10); chk("t5_pc0", 32'(pc_o), 0); chk("t5_cnt", 32'(cnt_o), 1);

    // reset mid-fetch: half full with a read in flight
    tick(); rst = 1'b1; tick();
    rst = 1'b0; take_i = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    smp(); chk("t6_pre_cnt", 32'(cnt_o), 2); chk("t6_rst_rd", 32'(mem_rd_o), 0); tick();
    rst = 1'b0;
    smp();
    chk("t6_vld",  32'(vld_o),      0);
    chk("t6_cnt",  32'(cnt_o),      0);
    chk("t6_byte", 32'(byte_o),     0);
    chk("t6_pc",   32'(pc_o),       0);
    chk("t6_st",   32'(dbg_st_o),   32'(sFILL));
    chk("t6_rd",   32'(mem_rd_o),   1);
    chk("t6_addr", 32'(mem_addr_o), 0);
    tick();
    smp(); chk("t6_vld_w", 32'(vld_o), 0); tick();
    smp(); chk("t6_vld2", 32'(vld_o), 1); chk("t6_b0", 32'(byte_o), 32'h10); chk("t6_pc0", 32'(pc_o), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
